// File: rtl/alu_muldiv_seq.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and restoring divider, one bit per cycle.
// Build option MULDIV_FASTPATH_EN: trivial multiplies (zero operand) and divides with |a|<|b| finish in one cycle.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | iterating, one multiplier/divider bit per cycle, WIDTH cycles
// DONE  | result held with out_valid until out_ready
module alu_muldiv_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               sign_a;
    logic               sign_b;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;

    logic               sgn_a_in;
    logic               sgn_b_in;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic               bypass;
    logic [WIDTH-1:0]   bypass_res;
    logic               bypass_dbz;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic [2*WIDTH-1:0] mul_fix;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [WIDTH-1:0]   calc_res;

    // Operand decode for the accept cycle
    always_comb begin
        sgn_a_in   = 1'b0;
        sgn_b_in   = 1'b0;
        bypass     = 1'b0;
        bypass_res = '0;
        bypass_dbz = 1'b0;
        case (op)
            3'b001, 3'b100, 3'b110: begin
                sgn_a_in = a[WIDTH-1];
                sgn_b_in = b[WIDTH-1];
            end
            3'b010:  sgn_a_in = a[WIDTH-1];
            default: ;
        endcase
        mag_a_in = sgn_a_in ? -a : a;
        mag_b_in = sgn_b_in ? -b : b;

        if (op[2] && (b == '0)) begin
            bypass     = 1'b1;
            bypass_res = op[1] ? a : '1;
            bypass_dbz = 1'b1;
        end else if (op[2] && !op[0] && (a == MIN_NEG) && (b == '1)) begin
            bypass     = 1'b1;
            bypass_res = op[1] ? '0 : a;
        end
`ifdef MULDIV_FASTPATH_EN
        else if (!op[2] && ((a == '0) || (b == '0))) begin
            bypass     = 1'b1;
            bypass_res = '0;
        end else if (op[2] && (mag_a_in < mag_b_in)) begin
            bypass     = 1'b1;
            bypass_res = op[1] ? a : '0;
        end
`endif
    end

    // One iteration of both datapaths; only the one matching op_r is used
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
        prod_step = {mul_sum, prod[WIDTH-1:1]};
        mul_fix   = (sign_a ^ sign_b) ? -prod_step : prod_step;

        div_shift = {rem_r, quo_r[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        // The difference is below mag_b, so the dropped top bit is always zero
        div_diff  = div_shift[WIDTH-1:0] - mag_b;
        rem_step  = div_ge ? div_diff : div_shift[WIDTH-1:0];
        quo_step  = {quo_r[WIDTH-2:0], div_ge};
        q_fix     = (sign_a ^ sign_b) ? -quo_step : quo_step;
        r_fix     = sign_a ? -rem_step : rem_step;

        if (op_r[2])
            calc_res = op_r[1] ? r_fix : q_fix;
        else if (op_r[1:0] == 2'b00)
            calc_res = mul_fix[WIDTH-1:0];
        else
            calc_res = mul_fix[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            op_r        <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            cnt         <= '0;
            prod        <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r     <= op;
                        mag_a    <= mag_a_in;
                        mag_b    <= mag_b_in;
                        sign_a   <= sgn_a_in;
                        sign_b   <= sgn_b_in;
                        cnt      <= '0;
                        prod     <= {{WIDTH{1'b0}}, mag_b_in};
                        rem_r    <= '0;
                        quo_r    <= mag_a_in;
                        in_ready <= 1'b0;
                        if (bypass) begin
                            result      <= bypass_res;
                            div_by_zero <= bypass_dbz;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    prod  <= prod_step;
                    rem_r <= rem_step;
                    quo_r <= quo_step;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        result    <= calc_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed plan vectors, random ops against a 128-bit arithmetic model,
// backpressure, flush and asynchronous reset aborts.
module tb_alu_muldiv_seq;

    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    alu_muldiv_seq #(.WIDTH(64)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: {div_by_zero, result} from plain wide arithmetic
    function automatic logic [64:0] model_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        logic signed [127:0] pp;
        logic [127:0]        pu;
        logic signed [63:0]  sx, sy, sq;
        sx = x;
        sy = y;
        case (o)
            3'd0: begin pu = {64'd0, x} * {64'd0, y}; return {1'b0, pu[63:0]}; end
            3'd1: begin pp = $signed({{64{x[63]}}, x}) * $signed({{64{y[63]}}, y}); return {1'b0, pp[127:64]}; end
            3'd2: begin pp = $signed({{64{x[63]}}, x}) * $signed({64'd0, y}); return {1'b0, pp[127:64]}; end
            3'd3: begin pu = {64'd0, x} * {64'd0, y}; return {1'b0, pu[127:64]}; end
            3'd4: begin
                if (y == 64'd0) return {1'b1, ONES};
                if (x == MIN_NEG && y == ONES) return {1'b0, x};
                sq = sx / sy;
                return {1'b0, sq};
            end
            3'd5: begin
                if (y == 64'd0) return {1'b1, ONES};
                return {1'b0, x / y};
            end
            3'd6: begin
                if (y == 64'd0) return {1'b1, x};
                if (x == MIN_NEG && y == ONES) return {1'b0, 64'd0};
                sq = sx % sy;
                return {1'b0, sq};
            end
            default: begin
                if (y == 64'd0) return {1'b1, x};
                return {1'b0, x % y};
            end
        endcase
    endfunction

    // Edges from the accept edge until out_valid is seen
    function automatic int model_lat(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [63:0] ax, ay;
        ax = x;
        ay = y;
        if (o[2] && y == 64'd0) return 0;
        if ((o == 3'd4 || o == 3'd6) && x == MIN_NEG && y == ONES) return 0;
`ifdef MULDIV_FASTPATH_EN
        if (!o[2] && (x == 64'd0 || y == 64'd0)) return 0;
        if (o[2]) begin
            if (!o[0] && x[63]) ax = -x;
            if (!o[0] && y[63]) ay = -y;
            if (ax < ay) return 0;
        end
`endif
        return (ax == ay) ? 64 : 64;
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y, input int hold,
                          output logic [63:0] r, output logic d, output int lat,
                          output logic busy_bad, output logic stable_bad);
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        op = 3'($urandom_range(0, 7));
        lat = 0; busy_bad = 1'b0; stable_bad = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk); #1; lat++;
        end
        if (in_ready) busy_bad = 1'b1;
        r = result;
        d = div_by_zero;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (result !== r || div_by_zero !== d || out_valid !== 1'b1 || in_ready !== 1'b0) stable_bad = 1'b1;
        end
        if (!out_valid) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end else begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic check_op(input string name, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                            input logic [63:0] exp_r, input logic exp_d, input int exp_lat);
        logic [63:0] r;
        logic        d, bb, sb;
        int          lat;
        run_op(o, x, y, 0, r, d, lat, bb, sb);
        checks++;
        if (r !== exp_r) begin errors++; $display("FAIL %s result got %h want %h", name, r, exp_r); end
        checks++;
        if (d !== exp_d) begin errors++; $display("FAIL %s div_by_zero got %b want %b", name, d, exp_d); end
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
        checks++;
        if (bb !== 1'b0) begin errors++; $display("FAIL %s in_ready high while busy", name); end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0 || result !== 64'd0 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got ov=%b res=%h dbz=%b want 0/0/0", out_valid, result, div_by_zero);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_directed();
        check_op("mul_7x-3",    3'd0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 64);
        check_op("mulhu_ones",  3'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64);
        check_op("mulh_ones",   3'd1, ONES, ONES, 64'd0, 1'b0, 64);
        check_op("mulhsu_-1x2", 3'd2, ONES, 64'd2, ONES, 1'b0, 64);
        check_op("div_-7/2",    3'd4, -64'sd7, 64'd2, -64'sd3, 1'b0, 64);
        check_op("rem_-7/2",    3'd6, -64'sd7, 64'd2, -64'sd1, 1'b0, 64);
        check_op("divu_100/7",  3'd5, 64'd100, 64'd7, 64'd14, 1'b0, 64);
        check_op("remu_100/7",  3'd7, 64'd100, 64'd7, 64'd2, 1'b0, 64);
        check_op("divu_by0",    3'd5, 64'd5, 64'd0, ONES, 1'b1, 0);
        check_op("remu_by0",    3'd7, 64'd5, 64'd0, 64'd5, 1'b1, 0);
        check_op("div_ovf",     3'd4, MIN_NEG, ONES, MIN_NEG, 1'b0, 0);
        check_op("rem_ovf",     3'd6, MIN_NEG, ONES, 64'd0, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [64:0] exp;
        logic [63:0] x, y;
        logic [2:0]  o;
        int          mode;
        for (int n = 0; n < 30; n++) begin
            o = 3'($urandom_range(0, 7));
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            mode = $urandom_range(0, 5);
            case (mode)
                1: y = 64'($urandom_range(1, 15));
                2: y = 64'd0;
                3: begin x = MIN_NEG; y = ONES; end
                4: x = 64'($urandom_range(0, 100));
                5: y = -64'($urandom_range(1, 9));
                default: ;
            endcase
            exp = model_op(o, x, y);
            check_op($sformatf("rand%0d_op%0d", n, o), o, x, y, exp[63:0], exp[64], model_lat(o, x, y));
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        logic        d, bb, sb;
        int          lat;
        run_op(3'd5, 64'd5, 64'd0, 10, r, d, lat, bb, sb);
        checks++;
        if (sb !== 1'b0) begin errors++; $display("FAIL backpressure_stable outputs changed while held got 1 want 0"); end
        checks++;
        if (r !== ONES || d !== 1'b1) begin errors++; $display("FAIL backpressure_value got %h/%b want %h/1", r, d, ONES); end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL handshake_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        run_op(3'd7, 64'd100, 64'd7, 0, r, d, lat, bb, sb);
        checks++;
        if (r !== 64'd2 || lat !== 64) begin errors++; $display("FAIL back_to_back got %h lat %0d want 2 lat 64", r, lat); end
    endtask

    task automatic test_flush();
        logic seen;
        op = 3'd0; a = 64'd9; b = 64'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_calc got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_wins got in_ready=%b want 1", in_ready); end
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_result got activity=1 want 0"); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] r;
        logic        d, bb, sb;
        int          lat;
        op = 3'd0; a = 64'd11; b = 64'd13; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 64'd0 || div_by_zero !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid got ov=%b res=%h dbz=%b rdy=%b want 0/0/0/1", out_valid, result, div_by_zero, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        run_op(3'd0, 64'd3, 64'd5, 0, r, d, lat, bb, sb);
        checks++;
        if (r !== 64'd15 || d !== 1'b0 || lat !== 64) begin
            errors++; $display("FAIL mul_after_reset got %h/%b lat %0d want 15/0 lat 64", r, d, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
